// File: rtl/forwarding_unit_pkg.sv
// forwarding_unit_pkg: forwarding select codes, register-zero constant and shadow-entry field widths
package forwarding_unit_pkg;
  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] FWD_REGFILE = 2'b00;
  localparam logic [SEL_W-1:0] FWD_MEMWB = 2'b01;
  localparam logic [SEL_W-1:0] FWD_EXMEM = 2'b10;
  localparam int REG_ZERO = 0;
  localparam int FLAG_W = 3;
  localparam int SRC_FLAG_W = 2;
endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one shadow-pipeline entry (clk, reset, load, d -> q); !load inserts an all-zero bubble
module hazard_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= (reset || !load) ? '0 : d;
endmodule

// File: rtl/forwarding_unit.sv
// forwarding_unit: EX/MEM/WB shadow pipeline driving EX operand forward selects, load-use stall and stall counter
module forwarding_unit
  import forwarding_unit_pkg::*;
#(
  parameter int REG_ADDR_LEN = 5,
  parameter int CNT_LEN = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_rs,
  input  logic [REG_ADDR_LEN-1:0] id_rt,
  input  logic                    id_uses_rs,
  input  logic                    id_uses_rt,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic                    id_reg_write,
  input  logic                    id_mem_read,
  input  logic                    flush,
  output logic [SEL_W-1:0]        fwd_sel_a,
  output logic [SEL_W-1:0]        fwd_sel_b,
  output logic                    stall,
  output logic [CNT_LEN-1:0]      stall_count
);
  localparam int A = REG_ADDR_LEN;
  localparam int MW = FLAG_W + A;
  localparam int EW = MW + SRC_FLAG_W + 2 * A;
  localparam logic [A-1:0] ZERO = A'(REG_ZERO);
  logic [EW-1:0] ex_q;
  logic [MW-1:0] mem_q, wb_q;
  logic ex_valid, ex_mem_read, ex_uses_rs, ex_uses_rt, wb_unused;
  logic [A-1:0] ex_dest, ex_rs, ex_rt;
  // EX entry layout: {valid, reg_write, mem_read, dest, uses_rs, uses_rt, rs, rt}; its top MW bits form the MEM/WB entry
  hazard_stage_reg #(.W(EW)) u_ex (
    .clk(clk), .reset(reset), .load(!stall && !flush),
    .d({id_valid, id_reg_write, id_mem_read, id_dest, id_uses_rs, id_uses_rt, id_rs, id_rt}),
    .q(ex_q)
  );
  hazard_stage_reg #(.W(MW)) u_mem (.clk(clk), .reset(reset), .load(1'b1), .d(ex_q[EW-1 -: MW]), .q(mem_q));
  hazard_stage_reg #(.W(MW)) u_wb (.clk(clk), .reset(reset), .load(1'b1), .d(mem_q), .q(wb_q));
  assign ex_valid = ex_q[EW-1];
  assign ex_mem_read = ex_q[EW-3];
  assign ex_dest = ex_q[EW-4 -: A];
  assign {ex_uses_rs, ex_uses_rt, ex_rs, ex_rt} = ex_q[2*A+1:0];
  assign wb_unused = wb_q[MW-3];
  function automatic logic hit(input logic v, input logic rw, input logic [A-1:0] dest,
                               input logic [A-1:0] src, input logic en);
    return en && v && rw && dest != ZERO && dest == src;
  endfunction
  always_comb begin
    fwd_sel_a = hit(mem_q[MW-1], mem_q[MW-2], mem_q[A-1:0], ex_rs, ex_uses_rs) ? FWD_EXMEM :
                hit(wb_q[MW-1], wb_q[MW-2], wb_q[A-1:0], ex_rs, ex_uses_rs) ? FWD_MEMWB : FWD_REGFILE;
    fwd_sel_b = hit(mem_q[MW-1], mem_q[MW-2], mem_q[A-1:0], ex_rt, ex_uses_rt) ? FWD_EXMEM :
                hit(wb_q[MW-1], wb_q[MW-2], wb_q[A-1:0], ex_rt, ex_uses_rt) ? FWD_MEMWB : FWD_REGFILE;
  end
  assign stall = id_valid && ex_valid && ex_mem_read && ex_dest != ZERO && !flush &&
                 ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));
  always_ff @(posedge clk)
    if (reset) stall_count <= '0;
    else if (stall && !(&stall_count)) stall_count <= stall_count + CNT_LEN'(1);
endmodule

// File: tb/tb_forwarding_unit.sv
// tb_forwarding_unit: scenario tasks with a queue scoreboard checking selects, stall and stall counters
module tb_forwarding_unit;
  typedef struct packed {
    logic v; logic [4:0] rs; logic [4:0] rt; logic urs; logic urt;
    logic [4:0] dest; logic rw; logic mr; logic fl;
  } ins_t;
  typedef struct packed {logic [1:0] a; logic [1:0] b; logic s; logic [31:0] n;} exp_t;
  logic clk = 0, reset = 1, id_valid = 0, id_uses_rs = 0, id_uses_rt = 0;
  logic id_reg_write = 0, id_mem_read = 0, flush = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dest = 0;
  logic [1:0] fwd_sel_a, fwd_sel_b, sel_a2, sel_b2;
  logic stall, stall2;
  logic [31:0] stall_count;
  logic [1:0] cnt2;
  int checks = 0, failures = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  forwarding_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall), .stall_count(stall_count)
  );
  forwarding_unit #(.REG_ADDR_LEN(5), .CNT_LEN(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_sel_a(sel_a2), .fwd_sel_b(sel_b2), .stall(stall2), .stall_count(cnt2)
  );
  function automatic ins_t mk(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                              input int dest, input logic rw, input logic mr, input logic fl);
    return '{v: v, rs: 5'(rs), rt: 5'(rt), urs: urs, urt: urt, dest: 5'(dest), rw: rw, mr: mr, fl: fl};
  endfunction
  function automatic exp_t mke(input logic [1:0] a, input logic [1:0] b, input logic s, input int n);
    return '{a: a, b: b, s: s, n: 32'(n)};
  endfunction
  task automatic drive(input ins_t i);
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_uses_rs = i.urs; id_uses_rt = i.urt;
    id_dest = i.dest; id_reg_write = i.rw; id_mem_read = i.mr; flush = i.fl;
  endtask
  task automatic pulse_reset;
    @(negedge clk); reset = 1; drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); reset = 0;
  endtask
  task automatic test_reset;
    exp_t x;
    @(negedge clk); reset = 0; drive(mk(1, 0, 0, 1, 0, 3, 1, 1, 0));
    @(negedge clk); drive(mk(1, 3, 5, 1, 1, 4, 1, 0, 0)); reset = 1;
    @(negedge clk); drive(mk(1, 3, 3, 1, 1, 3, 1, 1, 1));
    @(negedge clk); reset = 0; drive(mk(1, 3, 5, 1, 1, 4, 1, 0, 0));
    sb.push_back(mke(2'b00, 2'b00, 0, 0));
    #1; x = sb.pop_front();
    checks++; if (fwd_sel_a !== x.a) begin failures++; $display("FAIL reset sel_a got=%b exp=%b", fwd_sel_a, x.a); end
    checks++; if (fwd_sel_b !== x.b) begin failures++; $display("FAIL reset sel_b got=%b exp=%b", fwd_sel_b, x.b); end
    checks++; if (stall !== x.s) begin failures++; $display("FAIL reset stall got=%b exp=%b", stall, x.s); end
    checks++; if (stall_count !== x.n) begin failures++; $display("FAIL reset stall_count got=%0d exp=%0d", stall_count, x.n); end
    checks++; if ({sel_a2, sel_b2, stall2} !== 5'b0) begin failures++; $display("FAIL reset dut2 sel/stall got=%b exp=00000", {sel_a2, sel_b2, stall2}); end
    checks++; if (cnt2 !== 2'b00) begin failures++; $display("FAIL reset dut2 stall_count got=%b exp=00", cnt2); end
  endtask
  task automatic test_exmem_forward;
    ins_t p[4]; exp_t e[4]; exp_t x;
    p = '{mk(1, 0, 0, 1, 0, 1, 1, 0, 0), mk(1, 1, 1, 1, 1, 2, 1, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    e = '{mke(0, 0, 0, 0), mke(0, 0, 0, 0), mke(2, 2, 0, 0), mke(0, 0, 0, 0)};
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(p[c]); sb.push_back(e[c]); #1; x = sb.pop_front();
      checks++; if (fwd_sel_a !== x.a) begin failures++; $display("FAIL exmem c%0d sel_a got=%b exp=%b", c, fwd_sel_a, x.a); end
      checks++; if (fwd_sel_b !== x.b) begin failures++; $display("FAIL exmem c%0d sel_b got=%b exp=%b", c, fwd_sel_b, x.b); end
      checks++; if (stall !== x.s) begin failures++; $display("FAIL exmem c%0d stall got=%b exp=%b", c, stall, x.s); end
    end
  endtask
  task automatic test_load_use;
    ins_t p[4]; exp_t e[4]; exp_t x;
    p = '{mk(1, 0, 0, 1, 0, 3, 1, 1, 0), mk(1, 3, 5, 1, 1, 4, 1, 0, 0), mk(1, 3, 5, 1, 1, 4, 1, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    e = '{mke(0, 0, 0, 0), mke(0, 0, 1, 0), mke(0, 0, 0, 1), mke(1, 0, 0, 1)};
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(p[c]); sb.push_back(e[c]); #1; x = sb.pop_front();
      checks++; if (fwd_sel_a !== x.a) begin failures++; $display("FAIL load_use c%0d sel_a got=%b exp=%b", c, fwd_sel_a, x.a); end
      checks++; if (fwd_sel_b !== x.b) begin failures++; $display("FAIL load_use c%0d sel_b got=%b exp=%b", c, fwd_sel_b, x.b); end
      checks++; if (stall !== x.s) begin failures++; $display("FAIL load_use c%0d stall got=%b exp=%b", c, stall, x.s); end
      checks++; if (stall_count !== x.n) begin failures++; $display("FAIL load_use c%0d stall_count got=%0d exp=%0d", c, stall_count, x.n); end
    end
  endtask
  task automatic test_reg_zero;
    ins_t p[4]; exp_t e[4]; exp_t x;
    p = '{mk(1, 0, 0, 1, 0, 0, 1, 1, 0), mk(1, 0, 0, 1, 0, 0, 1, 0, 0), mk(1, 0, 0, 1, 1, 8, 1, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    e = '{mke(0, 0, 0, 0), mke(0, 0, 0, 0), mke(0, 0, 0, 0), mke(0, 0, 0, 0)};
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(p[c]); sb.push_back(e[c]); #1; x = sb.pop_front();
      checks++; if (fwd_sel_a !== x.a) begin failures++; $display("FAIL reg_zero c%0d sel_a got=%b exp=%b", c, fwd_sel_a, x.a); end
      checks++; if (fwd_sel_b !== x.b) begin failures++; $display("FAIL reg_zero c%0d sel_b got=%b exp=%b", c, fwd_sel_b, x.b); end
      checks++; if (stall !== x.s) begin failures++; $display("FAIL reg_zero c%0d stall got=%b exp=%b", c, stall, x.s); end
    end
  endtask
  task automatic test_priority;
    ins_t p[4]; exp_t e[4]; exp_t x;
    p = '{mk(1, 0, 0, 1, 0, 6, 1, 0, 0), mk(1, 0, 0, 1, 0, 6, 1, 0, 0), mk(1, 6, 6, 1, 1, 9, 1, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    e = '{mke(0, 0, 0, 0), mke(0, 0, 0, 0), mke(0, 0, 0, 0), mke(2, 2, 0, 0)};
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(p[c]); sb.push_back(e[c]); #1; x = sb.pop_front();
      checks++; if (fwd_sel_a !== x.a) begin failures++; $display("FAIL priority c%0d sel_a got=%b exp=%b", c, fwd_sel_a, x.a); end
      checks++; if (fwd_sel_b !== x.b) begin failures++; $display("FAIL priority c%0d sel_b got=%b exp=%b", c, fwd_sel_b, x.b); end
    end
  endtask
  task automatic test_memwb_forward;
    ins_t p[4]; exp_t e[4]; exp_t x;
    p = '{mk(1, 0, 0, 1, 0, 12, 1, 1, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(1, 0, 12, 1, 1, 13, 1, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    e = '{mke(0, 0, 0, 0), mke(0, 0, 0, 0), mke(0, 0, 0, 0), mke(0, 1, 0, 0)};
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(p[c]); sb.push_back(e[c]); #1; x = sb.pop_front();
      checks++; if (fwd_sel_a !== x.a) begin failures++; $display("FAIL memwb c%0d sel_a got=%b exp=%b", c, fwd_sel_a, x.a); end
      checks++; if (fwd_sel_b !== x.b) begin failures++; $display("FAIL memwb c%0d sel_b got=%b exp=%b", c, fwd_sel_b, x.b); end
      checks++; if (stall !== x.s) begin failures++; $display("FAIL memwb c%0d stall got=%b exp=%b", c, stall, x.s); end
    end
  endtask
  task automatic test_flush;
    ins_t p[4]; exp_t e[4]; exp_t x;
    p = '{mk(1, 0, 0, 1, 0, 7, 1, 1, 0), mk(1, 7, 0, 1, 0, 8, 1, 0, 1), mk(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    e = '{mke(0, 0, 0, 0), mke(0, 0, 0, 0), mke(0, 0, 0, 0), mke(0, 0, 0, 0)};
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(p[c]); sb.push_back(e[c]); #1; x = sb.pop_front();
      checks++; if (fwd_sel_a !== x.a) begin failures++; $display("FAIL flush c%0d sel_a got=%b exp=%b", c, fwd_sel_a, x.a); end
      checks++; if (stall !== x.s) begin failures++; $display("FAIL flush c%0d stall got=%b exp=%b", c, stall, x.s); end
      checks++; if (stall_count !== x.n) begin failures++; $display("FAIL flush c%0d stall_count got=%0d exp=%0d", c, stall_count, x.n); end
    end
  endtask
  task automatic test_reset_mid_stall;
    ins_t p[4]; exp_t e[4]; exp_t x;
    p = '{mk(1, 0, 0, 1, 0, 3, 1, 1, 0), mk(1, 3, 5, 1, 1, 4, 1, 0, 0), mk(1, 3, 5, 1, 1, 4, 1, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    e = '{mke(0, 0, 0, 0), mke(0, 0, 1, 0), mke(0, 0, 0, 0), mke(0, 0, 0, 0)};
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(p[c]); reset = (c == 1); sb.push_back(e[c]); #1; x = sb.pop_front();
      checks++; if (fwd_sel_a !== x.a) begin failures++; $display("FAIL rst_stall c%0d sel_a got=%b exp=%b", c, fwd_sel_a, x.a); end
      checks++; if (fwd_sel_b !== x.b) begin failures++; $display("FAIL rst_stall c%0d sel_b got=%b exp=%b", c, fwd_sel_b, x.b); end
      checks++; if (stall !== x.s) begin failures++; $display("FAIL rst_stall c%0d stall got=%b exp=%b", c, stall, x.s); end
      checks++; if (stall_count !== x.n) begin failures++; $display("FAIL rst_stall c%0d stall_count got=%0d exp=%0d", c, stall_count, x.n); end
    end
    reset = 0;
  endtask
  task automatic test_counter_saturation;
    exp_t x;
    logic [1:0] n2;
    pulse_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk); drive(mk(1, 3, 0, 1, 0, 3, 1, 1, 0));
      sb.push_back(mke((c >= 3 && c % 2 == 1) ? 2'b01 : 2'b00, 2'b00, c % 2 == 1, c / 2));
      n2 = (c / 2 > 3) ? 2'b11 : 2'(c / 2);
      #1; x = sb.pop_front();
      checks++; if (fwd_sel_a !== x.a) begin failures++; $display("FAIL counter c%0d sel_a got=%b exp=%b", c, fwd_sel_a, x.a); end
      checks++; if (stall !== x.s) begin failures++; $display("FAIL counter c%0d stall got=%b exp=%b", c, stall, x.s); end
      checks++; if (stall_count !== x.n) begin failures++; $display("FAIL counter c%0d stall_count got=%0d exp=%0d", c, stall_count, x.n); end
      checks++; if (stall2 !== x.s) begin failures++; $display("FAIL counter c%0d dut2 stall got=%b exp=%b", c, stall2, x.s); end
      checks++; if (cnt2 !== n2) begin failures++; $display("FAIL counter c%0d dut2 stall_count got=%b exp=%b", c, cnt2, n2); end
    end
  endtask
  initial begin
    test_reset();
    test_exmem_forward();
    test_load_use();
    test_reg_zero();
    test_priority();
    test_memwb_forward();
    test_flush();
    test_reset_mid_stall();
    test_counter_saturation();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/forwarding_unit.md
FORWARDING_UNIT -- requirements
Module: forwarding_unit

Interface
REQ-001 Parameter REG_ADDR_LEN, default 5, register-address width.
REQ-002 Parameter CNT_LEN, default 32, stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_rs, id_rt  input  REG_ADDR_LEN each  source registers of the ID instruction.
REQ-007 id_uses_rs, id_uses_rt  input  1 each  ID instruction reads rs / rt.
REQ-008 id_dest  input  REG_ADDR_LEN  destination of the ID instruction.
REQ-009 id_reg_write, id_mem_read  input  1 each  ID instruction writes a register / is a load.
REQ-010 flush  input  1  branch/jump kill of the ID instruction.
REQ-011 fwd_sel_a, fwd_sel_b  output  2 each  Mux3To1 selects for the EX operands A (rs) and B (rt).
REQ-012 stall  output  1  hold PC and IF/ID; insert a bubble into EX.
REQ-013 stall_count  output  CNT_LEN  number of stall cycles since reset.

Function
REQ-014 The unit SHALL keep a shadow pipeline of three entries, EX, MEM and WB; each entry holds valid, reg_write, mem_read and dest, and EX also holds rs, rt, uses_rs and uses_rt.
REQ-015 Every cycle, MEM SHALL load EX and WB SHALL load MEM.
REQ-016 EX SHALL load the ID fields with valid=id_valid only when stall=0 and flush=0; otherwise EX SHALL load a bubble (valid=0).
REQ-017 Select encoding: 2'b00 is the register-file value, 2'b01 is the MEM/WB result (in_1), 2'b10 is the EX/MEM result (in_2), and 2'b11 SHALL never be driven.
REQ-018 fwd_sel_a SHALL be 2'b10 when EX.uses_rs, MEM.valid, MEM.reg_write, MEM.dest!=0 and MEM.dest==EX.rs all hold.
REQ-019 Otherwise fwd_sel_a SHALL be 2'b01 when the same conditions hold against WB; otherwise fwd_sel_a SHALL be 2'b00.
REQ-020 fwd_sel_b SHALL follow REQ-018 and REQ-019 using EX.rt and EX.uses_rt.
REQ-021 MEM SHALL take priority over WB when both match.
REQ-022 Register 0 SHALL never be forwarded.
REQ-023 Selects SHALL be combinational from the shadow entries only, giving zero-cycle latency with respect to EX occupancy.
REQ-024 stall SHALL be 1 when id_valid, EX.valid, EX.mem_read, EX.dest!=0 and flush=0 all hold, and either (id_uses_rs and id_rs==EX.dest) or (id_uses_rt and id_rt==EX.dest).
REQ-025 A load-use hazard SHALL stall for exactly one cycle: the bubble inserted into EX clears the condition on the next cycle.
REQ-026 When flush and a hazard occur together, flush SHALL win: stall=0 and EX loads a bubble.
REQ-027 stall_count SHALL increment by 1 on every cycle with stall=1 and SHALL saturate at all-ones without wrapping.
REQ-028 A load followed by a dependent instruction two slots later SHALL NOT stall; that operand SHALL be forwarded with select 2'b01.

Reset
REQ-029 While reset=1 at a clock edge, all entries SHALL have valid cleared and all dest/rs/rt fields set to 0, and stall_count SHALL be 0.
REQ-030 Consequently, on the cycle after reset fwd_sel_a=fwd_sel_b=2'b00 and stall=0.
REQ-031 Reset asserted mid-stall SHALL discard all in-flight entries; no stall or forward SHALL survive reset.
REQ-032 reset SHALL take priority over flush and over stall.

Structure
REQ-033 A shared package SHALL hold the select constants FWD_REGFILE, FWD_MEMWB and FWD_EXMEM, the constant REG_ZERO, and the shadow-entry field widths.
REQ-034 One sub-module, hazard_stage_reg, SHALL implement a single shadow entry with load/bubble control and synchronous reset; it SHALL be instantiated three times.
REQ-035 The select outputs SHALL connect directly to the sel ports of the two Mux3To1 EX-operand muxes.

Verification
REQ-036 addi $1 followed by add $2,$1,$1 -> in the cycle the add is in EX: fwd_sel_a=fwd_sel_b=2'b10, stall=0.
REQ-037 lw $3 followed by sub $4,$3,$5 -> stall=1 for one cycle and stall_count=1; once sub reaches EX: fwd_sel_a=2'b01, fwd_sel_b=2'b00.
REQ-038 Writes to $0, then a reader of $0 -> both selects stay 2'b00 throughout.
REQ-039 $6 written by the MEM and WB entries simultaneously, EX reads $6 -> select is 2'b10.
REQ-040 lw $7 with a dependent instruction in ID and flush=1 in the same cycle -> stall=0, EX becomes a bubble, stall_count unchanged.
REQ-041 reset pulsed during a stall cycle, and separately CNT_LEN=2 with 5 forced stalls -> after reset: stall=0, selects 2'b00, stall_count=0; counter case ends at stall_count=2'b11.
